// File: rtl/vector_requant_pack.sv
// Requantises 40b psums to int8 (bias, scale, round-shift, relu, saturate),
// packs bytes little-endian into words and queues them in an output FIFO.
module vector_requant_pack #(
    parameter int IN_WIDTH    = 40,
    parameter int SCALE_WIDTH = 16,
    parameter int LANES       = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_vld,
    input  logic signed [IN_WIDTH-1:0]    in_data,
    input  logic                          in_last,
    input  logic signed [31:0]            cfg_bias,
    input  logic signed [SCALE_WIDTH-1:0] cfg_scale,
    input  logic [5:0]                    cfg_shift,
    input  logic                          cfg_relu,
    input  logic                          ovf_clr,
    output logic                          out_vld,
    output logic [8*LANES-1:0]            out_data,
    output logic [LANES-1:0]              out_be,
    input  logic                          out_rdy,
    output logic                          busy,
    output logic                          ovf
);

    localparam int PW = IN_WIDTH + SCALE_WIDTH + 1;
    localparam int RW = PW + 1;
    localparam int WW = 8 * LANES;
    localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_LANE = CW'(LANES - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);
    localparam logic signed [RW-1:0] SAT_HI = RW'(127);
    localparam logic signed [RW-1:0] SAT_LO = RW'(-128);

    logic                       s1_vld, s1_last;
    logic signed [IN_WIDTH:0]   s1_q, s1_d;
    logic                       s2_vld, s2_last;
    logic signed [PW-1:0]       p_q, p_d;
    logic                       s3_vld, s3_last;
    logic [7:0]                 s3_byte, byte_d;
    logic signed [RW-1:0]       pe, rnd, r;

    always_comb begin
        s1_d = (IN_WIDTH + 1)'(in_data) + (IN_WIDTH + 1)'(cfg_bias);
        p_d  = PW'(s1_q) * PW'(cfg_scale);
    end

    // Rounding offset is added in one extra bit so it can never wrap.
    always_comb begin
        pe  = RW'(p_q);
        rnd = '0;
        if (cfg_shift != 6'd0)
            rnd = RW'(1) << (cfg_shift - 6'd1);
        r = (pe + rnd) >>> cfg_shift;
        if (cfg_relu && r[RW-1])
            byte_d = 8'h00;
        else if (r > SAT_HI)
            byte_d = 8'h7f;
        else if (r < SAT_LO)
            byte_d = 8'h80;
        else
            byte_d = r[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_last <= 1'b0;
            s1_q    <= '0;
            s2_vld  <= 1'b0;
            s2_last <= 1'b0;
            p_q     <= '0;
            s3_vld  <= 1'b0;
            s3_last <= 1'b0;
            s3_byte <= '0;
        end else begin
            s1_vld  <= in_vld;
            s1_last <= in_vld & in_last;
            s1_q    <= s1_d;
            s2_vld  <= s1_vld;
            s2_last <= s1_last;
            p_q     <= p_d;
            s3_vld  <= s2_vld;
            s3_last <= s2_last;
            s3_byte <= byte_d;
        end
    end

    logic [CW-1:0]    cnt, cnt_n;
    logic [WW-1:0]    pk_data, pk_data_n, w_data;
    logic [LANES-1:0] pk_be, pk_be_n, w_be;
    logic             push;

    always_comb begin
        cnt_n     = cnt;
        pk_data_n = pk_data;
        pk_be_n   = pk_be;
        w_data    = pk_data;
        w_be      = pk_be;
        push      = 1'b0;
        if (s3_vld) begin
            w_data[8*cnt +: 8] = s3_byte;
            w_be[cnt]          = 1'b1;
            if (s3_last || cnt == LAST_LANE) begin
                push      = 1'b1;
                pk_data_n = '0;
                pk_be_n   = '0;
                cnt_n     = '0;
            end else begin
                pk_data_n = w_data;
                pk_be_n   = w_be;
                cnt_n     = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            pk_data <= '0;
            pk_be   <= '0;
        end else begin
            cnt     <= cnt_n;
            pk_data <= pk_data_n;
            pk_be   <= pk_be_n;
        end
    end

    logic [WW-1:0]    mem_d  [FIFO_DEPTH];
    logic [LANES-1:0] mem_be [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             pop, full, wr_en, drop;

    // A pop frees the head slot in the same edge, so a full FIFO still accepts.
    always_comb begin
        pop   = out_vld & out_rdy;
        full  = (count == FULL_CNT);
        wr_en = push & (~full | pop);
        drop  = push & full & ~pop;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_d[wr_ptr]  <= w_data;
            mem_be[wr_ptr] <= w_be;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

    always_comb begin
        out_vld  = (count != '0);
        out_data = out_vld ? mem_d[rd_ptr] : '0;
        out_be   = out_vld ? mem_be[rd_ptr] : '0;
        busy     = s1_vld | s2_vld | s3_vld | (cnt != '0) | out_vld;
    end

endmodule

// File: tb/tb_vector_requant_pack.sv
// Bench for vector_requant_pack: vector table for the arithmetic plus
// scoreboarded sequences for packing, flush, backpressure and reset.
module tb_vector_requant_pack;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_vld, in_last;
    logic signed [39:0] in_data;
    logic signed [31:0] cfg_bias;
    logic signed [15:0] cfg_scale;
    logic [5:0]         cfg_shift;
    logic               cfg_relu, ovf_clr;
    logic               out_vld, out_rdy, busy, ovf;
    logic [63:0]        out_data;
    logic [7:0]         out_be;

    vector_requant_pack dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data),
        .in_last(in_last), .cfg_bias(cfg_bias), .cfg_scale(cfg_scale),
        .cfg_shift(cfg_shift), .cfg_relu(cfg_relu), .ovf_clr(ovf_clr),
        .out_vld(out_vld), .out_data(out_data), .out_be(out_be),
        .out_rdy(out_rdy), .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  be;
    } word_t;

    typedef struct {
        logic signed [39:0] din;
        logic signed [31:0] bias;
        logic signed [15:0] scale;
        logic [5:0]         shift;
        logic               relu;
        logic [7:0]         exp;
    } vec_t;

    word_t sbq[$];
    vec_t  vt[16];
    int    total = 0;
    int    bad = 0;
    int    lat;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_vld && out_rdy) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got %h be %h, nothing expected", out_data, out_be);
            end else begin
                word_t w;
                w = sbq.pop_front();
                chk("word_data", out_data, w.d);
                chk("word_be", {56'h0, out_be}, {56'h0, w.be});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [39:0] d, input logic last);
        in_vld  = 1'b1;
        in_data = d;
        in_last = last;
        tick();
        in_vld  = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || sbq.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        chk(name, {63'h0, n >= 200}, 64'h0);
    endtask

    function automatic word_t seq_word(input int base, input int n);
        word_t w;
        w.d  = '0;
        w.be = '0;
        for (int i = 0; i < n; i++) begin
            w.d[8*i +: 8] = 8'(base + i);
            w.be[i]       = 1'b1;
        end
        return w;
    endfunction

    task automatic set_cfg(input logic signed [31:0] b, input logic signed [15:0] s,
                           input logic [5:0] sh, input logic rl);
        cfg_bias  = b;
        cfg_scale = s;
        cfg_shift = sh;
        cfg_relu  = rl;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{40'sd1,     32'sd0,   16'sd3,     6'd2,  1'b0, 8'h01};
        vt[1]  = '{-40'sd2,    32'sd0,   16'sd3,     6'd2,  1'b0, 8'hff};
        vt[2]  = '{40'sd50,    32'sd0,   16'sd3,     6'd2,  1'b0, 8'h26};
        vt[3]  = '{40'sd1000,  32'sd0,   16'sd1,     6'd0,  1'b0, 8'h7f};
        vt[4]  = '{-40'sd1000, 32'sd0,   16'sd1,     6'd0,  1'b0, 8'h80};
        vt[5]  = '{-40'sd1000, 32'sd0,   16'sd1,     6'd0,  1'b1, 8'h00};
        vt[6]  = '{40'sd3,     -32'sd5,  16'sd1,     6'd0,  1'b1, 8'h00};
        vt[7]  = '{40'sd5,     32'sd10,  -16'sd2,    6'd1,  1'b0, 8'hf1};
        vt[8]  = '{40'sd3,     32'sd0,   16'sd1,     6'd1,  1'b0, 8'h02};
        vt[9]  = '{-40'sd3,    32'sd0,   16'sd1,     6'd1,  1'b0, 8'hff};
        vt[10] = '{40'sh7f_ffff_ffff, 32'sd0, 16'sh7fff, 6'd40, 1'b0, 8'h7f};
        vt[11] = '{40'sd100,   32'sd0,   16'sd1,     6'd47, 1'b0, 8'h00};
        vt[12] = '{-40'sd128,  32'sd0,   16'sd1,     6'd0,  1'b0, 8'h80};
        vt[13] = '{40'sd128,   32'sd0,   16'sd1,     6'd0,  1'b0, 8'h7f};
        vt[14] = '{-40'sd129,  32'sd0,   16'sd1,     6'd0,  1'b0, 8'h80};
        vt[15] = '{40'sd0,     32'sh8000_0000, -16'sd1, 6'd24, 1'b0, 8'h7f};

        rst     = 1'b1;
        in_vld  = 1'b0;
        in_last = 1'b0;
        in_data = '0;
        ovf_clr = 1'b0;
        out_rdy = 1'b1;
        set_cfg(32'sd0, 16'sd1, 6'd0, 1'b0);
        repeat (3) tick();
        chk("rst_out_vld", {63'h0, out_vld}, 64'h0);
        chk("rst_out_data", out_data, 64'h0);
        chk("rst_out_be", {56'h0, out_be}, 64'h0);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_ovf", {63'h0, ovf}, 64'h0);
        rst = 1'b0;
        tick();

        // full word of 0..7, also measures input-to-output latency
        sbq.push_back(seq_word(0, 8));
        for (int i = 0; i < 8; i++)
            drive(40'(i), 1'b0);
        lat = 0;
        while (!out_vld && lat < 10) begin
            tick();
            lat++;
        end
        total++;
        if (lat < 3 || lat > 4) begin
            bad++;
            $display("FAIL latency: got %0d cycles expected 3..4", lat);
            lat = 3;
        end
        wait_idle("idle_full_word");

        foreach (vt[i]) begin
            set_cfg(vt[i].bias, vt[i].scale, vt[i].shift, vt[i].relu);
            sbq.push_back('{d: {56'h0, vt[i].exp}, be: 8'h01});
            drive(vt[i].din, 1'b1);
            wait_idle("idle_vec");
        end

        set_cfg(32'sd0, 16'sd1, 6'd0, 1'b0);
        sbq.push_back('{d: 64'h0000_0000_0033_2211, be: 8'h07});
        sbq.push_back('{d: 64'h0000_0000_0000_0044, be: 8'h01});
        drive(40'h11, 1'b0);
        drive(40'h22, 1'b0);
        drive(40'h33, 1'b1);
        drive(40'h44, 1'b1);
        wait_idle("idle_partial");

        // backpressure: 5 words into a 4-deep FIFO, last one dropped
        out_rdy = 1'b0;
        for (int k = 0; k < 4; k++)
            sbq.push_back(seq_word(8 * k, 8));
        for (int i = 0; i < 40; i++)
            drive(40'(i), 1'b0);
        repeat (lat + 2) tick();
        chk("bp_ovf_set", {63'h0, ovf}, 64'h1);
        chk("bp_out_vld", {63'h0, out_vld}, 64'h1);
        chk("bp_busy", {63'h0, busy}, 64'h1);
        begin
            logic [63:0] held;
            held = out_data;
            repeat (3) tick();
            chk("bp_hold_data", out_data, held);
            chk("bp_hold_head", out_data, 64'h0706_0504_0302_0100);
        end
        out_rdy = 1'b1;
        wait_idle("idle_bp_drain");
        chk("bp_empty", {63'h0, out_vld}, 64'h0);
        chk("bp_ovf_sticky", {63'h0, ovf}, 64'h1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_cleared", {63'h0, ovf}, 64'h0);

        // fill, then land a push on the same edge as a pop while full
        out_rdy = 1'b0;
        for (int k = 0; k < 5; k++)
            sbq.push_back(seq_word(40 + 8 * k, 8));
        for (int i = 40; i < 72; i++)
            drive(40'(i), 1'b0);
        repeat (lat + 2) tick();
        for (int i = 72; i < 80; i++)
            drive(40'(i), 1'b0);
        repeat (lat - 1) tick();
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        repeat (3) tick();
        chk("full_pushpop_no_drop", {63'h0, ovf}, 64'h0);
        out_rdy = 1'b1;
        wait_idle("idle_full_pushpop");

        // reset mid-tile: two words queued and five bytes in the packer
        out_rdy = 1'b0;
        for (int i = 0; i < 21; i++)
            drive(40'(i), 1'b0);
        repeat (lat) tick();
        chk("pre_rst_busy", {63'h0, busy}, 64'h1);
        rst = 1'b1;
        tick();
        chk("midrst_out_vld", {63'h0, out_vld}, 64'h0);
        chk("midrst_busy", {63'h0, busy}, 64'h0);
        chk("midrst_out_be", {56'h0, out_be}, 64'h0);
        chk("midrst_out_data", out_data, 64'h0);
        rst = 1'b0;
        out_rdy = 1'b1;
        tick();
        sbq.push_back('{d: 64'h0000_0000_0000_0201, be: 8'h03});
        drive(40'h01, 1'b0);
        drive(40'h02, 1'b1);
        wait_idle("idle_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
